spi_pi_mem_bridge: RTL and testbench

- SPI slave (mode 0, MSB first) connecting the Raspberry Pi SPI header pins to port s2 of the shared Nios/Pi dual-port memory: 128 words × 32 bits, 1-cycle registered read.
- Lets the Pi read and write mailbox words that the Nios accesses through its own port.
- All logic runs in the 50 MHz system domain; SPI pins are oversampled.

---
 rtl/spi_pi_mem_bridge.sv | 222 ++++++++++++++++++++++
 tb/tb_spi_pi_mem_bridge.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_pi_mem_bridge.sv
// SPI mode-0 slave bridging the Raspberry Pi header to port s2 of the shared
// Nios/Pi mailbox memory; SPI pins are oversampled in the iCLK domain.
module spi_pi_mem_bridge #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int RD_LATENCY  = 1
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iSPI_CLK,
    input  logic              iSPI_CS_N,
    input  logic              iSPI_MOSI,
    output logic              oSPI_MISO,
    output logic [ADDR_W-1:0] oMEM_ADDR,
    output logic              oMEM_WE,
    output logic [DATA_W-1:0] oMEM_WDATA,
    input  logic [DATA_W-1:0] iMEM_RDATA,
    output logic              oXFER_DONE,
    output logic              oXFER_ERR
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        RD_FETCH,
        RD_DATA,
        WR_DATA
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclkSync_q, csSync_q, mosiSync_q;
    logic                   sclkPrev_q, csPrev_q;

    logic [CNT_W-1:0]  bitCnt_q, bitCnt_d;
    logic              wordDone_q, wordDone_d;
    logic [3:0]        fetchCnt_q, fetchCnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic [DATA_W-1:0] rxShift_q, rxShift_d;
    logic [DATA_W-1:0] txShift_q, txShift_d;
    logic [DATA_W-1:0] memWdata_q, memWdata_d;
    logic              memWe_q, memWe_d;
    logic              miso_q, miso_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              sclkS, csS, mosiS;
    logic              riseP, fallP, csFall, csRise;
    logic              lastBit;
    logic [DATA_W-1:0] rxNext;

    assign sclkS   = sclkSync_q[SYNC_STAGES-1];
    assign csS     = csSync_q[SYNC_STAGES-1];
    assign mosiS   = mosiSync_q[SYNC_STAGES-1];
    assign riseP   = sclkS & ~sclkPrev_q;
    assign fallP   = ~sclkS & sclkPrev_q;
    // The CS synchronizer resets low, so a frame already running at reset
    // release produces no falling edge and is ignored until CS toggles.
    assign csFall  = ~csS & csPrev_q;
    assign csRise  = csS & ~csPrev_q;
    assign lastBit = (bitCnt_q == CNT_W'(DATA_W - 1));
    assign rxNext  = {rxShift_q[DATA_W-2:0], mosiS};

    always_comb begin
        state_d    = state_q;
        bitCnt_d   = bitCnt_q;
        wordDone_d = wordDone_q;
        fetchCnt_d = fetchCnt_q;
        addr_d     = addr_q;
        memAddr_d  = memAddr_q;
        rxShift_d  = rxShift_q;
        txShift_d  = txShift_q;
        memWdata_d = memWdata_q;
        memWe_d    = 1'b0;
        miso_d     = miso_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (csFall) begin
                    state_d    = CMD;
                    bitCnt_d   = '0;
                    wordDone_d = 1'b0;
                    rxShift_d  = '0;
                end
            end
            CMD: begin
                miso_d = 1'b0;
                if (riseP) begin
                    rxShift_d = rxNext;
                    bitCnt_d  = bitCnt_q + 1'b1;
                    if (bitCnt_q == CNT_W'(7)) begin
                        bitCnt_d = '0;
                        addr_d   = rxNext[ADDR_W-1:0];
                        if (rxNext[7]) begin
                            state_d = WR_DATA;
                        end else begin
                            state_d    = RD_FETCH;
                            memAddr_d  = rxNext[ADDR_W-1:0];
                            fetchCnt_d = '0;
                        end
                    end
                end
            end
            // SCLK edges seen here violate the rate limit and are dropped.
            RD_FETCH: begin
                if (fetchCnt_q == 4'(RD_LATENCY)) begin
                    txShift_d = iMEM_RDATA;
                    state_d   = RD_DATA;
                end else begin
                    fetchCnt_d = fetchCnt_q + 1'b1;
                end
            end
            RD_DATA: begin
                if (fallP) begin
                    miso_d    = txShift_q[DATA_W-1];
                    txShift_d = txShift_q << 1;
                end
                if (riseP) begin
                    bitCnt_d = bitCnt_q + 1'b1;
                    if (lastBit) begin
                        bitCnt_d   = '0;
                        wordDone_d = 1'b1;
                        addr_d     = addr_q + 1'b1;
                        memAddr_d  = addr_q + 1'b1;
                        fetchCnt_d = '0;
                        state_d    = RD_FETCH;
                    end
                end
            end
            WR_DATA: begin
                miso_d = 1'b0;
                if (riseP) begin
                    rxShift_d = rxNext;
                    bitCnt_d  = bitCnt_q + 1'b1;
                    if (lastBit) begin
                        bitCnt_d   = '0;
                        wordDone_d = 1'b1;
                        memWe_d    = 1'b1;
                        memAddr_d  = addr_q;
                        memWdata_d = rxNext;
                        addr_d     = addr_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Judged on next-state values so a word completing together with
        // the CS rise still counts as a clean end of frame.
        if (state_q != IDLE && csRise) begin
            state_d = IDLE;
            miso_d  = 1'b0;
            if (bitCnt_d == '0 && wordDone_d)
                done_d = 1'b1;
            else
                err_d = 1'b1;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            sclkSync_q <= '0;
            csSync_q   <= '0;
            mosiSync_q <= '0;
            sclkPrev_q <= 1'b0;
            csPrev_q   <= 1'b0;
        end else begin
            sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], iSPI_CLK};
            csSync_q   <= {csSync_q[SYNC_STAGES-2:0], iSPI_CS_N};
            mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], iSPI_MOSI};
            sclkPrev_q <= sclkS;
            csPrev_q   <= csS;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q    <= IDLE;
            bitCnt_q   <= '0;
            wordDone_q <= 1'b0;
            fetchCnt_q <= '0;
            addr_q     <= '0;
            memAddr_q  <= '0;
            rxShift_q  <= '0;
            txShift_q  <= '0;
            memWdata_q <= '0;
            memWe_q    <= 1'b0;
            miso_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitCnt_q   <= bitCnt_d;
            wordDone_q <= wordDone_d;
            fetchCnt_q <= fetchCnt_d;
            addr_q     <= addr_d;
            memAddr_q  <= memAddr_d;
            rxShift_q  <= rxShift_d;
            txShift_q  <= txShift_d;
            memWdata_q <= memWdata_d;
            memWe_q    <= memWe_d;
            miso_q     <= miso_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign oSPI_MISO  = miso_q;
    assign oMEM_ADDR  = memAddr_q;
    assign oMEM_WE    = memWe_q;
    assign oMEM_WDATA = memWdata_q;
    assign oXFER_DONE = done_q;
    assign oXFER_ERR  = err_q;

endmodule

// File: tb/tb_spi_pi_mem_bridge.sv
// Scoreboard bench for spi_pi_mem_bridge: a Pi-side SPI master at 4 MHz and a
// 128x32 registered-read memory model on port s2.
`timescale 1ns/1ps
module tb_spi_pi_mem_bridge;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iSPI_CLK = 1'b0;
    logic        iSPI_CS_N = 1'b1;
    logic        iSPI_MOSI = 1'b0;
    logic        oSPI_MISO;
    logic [6:0]  oMEM_ADDR;
    logic        oMEM_WE;
    logic [31:0] oMEM_WDATA;
    logic [31:0] iMEM_RDATA;
    logic        oXFER_DONE;
    logic        oXFER_ERR;

    logic [31:0] mem [128];
    logic        pokeEn = 1'b0;
    logic [6:0]  pokeAddr = '0;
    logic [31:0] pokeData = '0;

    logic [38:0] expWrQ[$];
    logic [31:0] expRdQ[$];
    int          vecCnt = 0;
    int          errCnt = 0;
    int          gotDone = 0;
    int          gotErr = 0;
    int          expDone = 0;
    int          expErr = 0;
    int          unstableCnt = 0;
    bit          rdFrame = 1'b0;
    int          monBit = 0;
    logic [31:0] monWord = '0;

    spi_pi_mem_bridge dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iSPI_CLK   (iSPI_CLK),
        .iSPI_CS_N  (iSPI_CS_N),
        .iSPI_MOSI  (iSPI_MOSI),
        .oSPI_MISO  (oSPI_MISO),
        .oMEM_ADDR  (oMEM_ADDR),
        .oMEM_WE    (oMEM_WE),
        .oMEM_WDATA (oMEM_WDATA),
        .iMEM_RDATA (iMEM_RDATA),
        .oXFER_DONE (oXFER_DONE),
        .oXFER_ERR  (oXFER_ERR)
    );

    always #10 iCLK = ~iCLK;

    // Memory model with a backdoor poke port so only one process writes mem.
    always @(posedge iCLK) begin
        if (pokeEn)
            mem[pokeAddr] <= pokeData;
        else if (oMEM_WE)
            mem[oMEM_ADDR] <= oMEM_WDATA;
        iMEM_RDATA <= mem[oMEM_ADDR];
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        vecCnt++;
        if (got !== want) begin
            errCnt++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, want, $time);
        end
    endtask

    task automatic pokeMem(input logic [6:0] a, input logic [31:0] d);
        @(negedge iCLK);
        pokeEn   = 1'b1;
        pokeAddr = a;
        pokeData = d;
        @(negedge iCLK);
        pokeEn   = 1'b0;
    endtask

    task automatic spiBits(input logic [31:0] val, input int n);
        logic pre;
        for (int i = n - 1; i >= 0; i--) begin
            iSPI_MOSI = val[i];
            #105;
            pre = oSPI_MISO;
            #20;
            iSPI_CLK = 1'b1;
            if (rdFrame && pre !== oSPI_MISO) unstableCnt++;
            #125;
            iSPI_CLK = 1'b0;
        end
    endtask

    task automatic csLow();
        @(negedge iCLK);
        #3;
        iSPI_CS_N = 1'b0;
        #125;
    endtask

    task automatic csHigh();
        #125;
        iSPI_CS_N = 1'b1;
        #400;
    endtask

    // Full frame: pushes expected writes or read words, then drives the bus.
    task automatic applyStimulus(input logic [7:0] cmd, input int nWords,
                                 input logic [31:0] w0, input logic [31:0] w1,
                                 input logic [31:0] w2);
        logic [31:0] w [3];
        logic [6:0]  a;
        w[0] = w0; w[1] = w1; w[2] = w2;
        a = cmd[6:0];
        rdFrame = !cmd[7];
        for (int i = 0; i < nWords; i++) begin
            if (cmd[7]) expWrQ.push_back({a, w[i]});
            else        expRdQ.push_back(w[i]);
            a = a + 7'd1;
        end
        expDone++;
        csLow();
        spiBits({24'h0, cmd}, 8);
        for (int i = 0; i < nWords; i++)
            spiBits(cmd[7] ? w[i] : 32'h0, 32);
        csHigh();
        rdFrame = 1'b0;
    endtask

    task automatic checkFrame(input string tag);
        checkOutput({tag, "_done_cnt"}, gotDone, expDone);
        checkOutput({tag, "_err_cnt"}, gotErr, expErr);
        checkOutput({tag, "_wr_pending"}, expWrQ.size(), 0);
        checkOutput({tag, "_rd_pending"}, expRdQ.size(), 0);
    endtask

    // Write-port monitor: every WE pulse must match the head of the queue.
    always @(negedge iCLK) begin
        if (oXFER_DONE) gotDone++;
        if (oXFER_ERR)  gotErr++;
        if (oMEM_WE) begin
            if (expWrQ.size() == 0) begin
                vecCnt++;
                errCnt++;
                $display("[TB] FAIL unexpected_we: addr 0x%02h data 0x%08h at %0t", oMEM_ADDR, oMEM_WDATA, $time);
            end else begin
                logic [38:0] e;
                e = expWrQ.pop_front();
                checkOutput("we_addr", {25'h0, oMEM_ADDR}, {25'h0, e[38:32]});
                checkOutput("we_data", oMEM_WDATA, e[31:0]);
            end
        end
    end

    // MISO monitor: the Pi samples on SCLK rise; CS fall (SCLK low) restarts.
    always @(posedge iSPI_CLK or negedge iSPI_CS_N) begin
        if (!iSPI_CLK) begin
            monBit  = 0;
            monWord = '0;
        end else if (!iSPI_CS_N && rdFrame) begin
            monWord = {monWord[30:0], oSPI_MISO};
            monBit++;
            if (monBit == 8) begin
                checkOutput("rd_cmd_miso", monWord, 32'h0);
                monWord = '0;
            end else if (monBit > 8 && ((monBit - 8) % 32) == 0) begin
                if (expRdQ.size() == 0) begin
                    vecCnt++;
                    errCnt++;
                    $display("[TB] FAIL unexpected_rd_word: got 0x%08h with empty queue", monWord);
                end else begin
                    checkOutput("rd_word", monWord, expRdQ.pop_front());
                end
                monWord = '0;
            end
        end
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish, vectors %0d", vecCnt);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #55;
        checkOutput("rst_miso", {31'h0, oSPI_MISO}, 32'h0);
        checkOutput("rst_we", {31'h0, oMEM_WE}, 32'h0);
        checkOutput("rst_addr", {25'h0, oMEM_ADDR}, 32'h0);
        checkOutput("rst_wdata", oMEM_WDATA, 32'h0);
        checkOutput("rst_done", {31'h0, oXFER_DONE}, 32'h0);
        checkOutput("rst_err", {31'h0, oXFER_ERR}, 32'h0);
        #50;
        iRST = 1'b0;
        #200;

        $display("[TB] single write 0x85 / 0xDEADBEEF");
        applyStimulus(8'h85, 1, 32'hDEADBEEF, 32'h0, 32'h0);
        checkFrame("wr1");

        $display("[TB] single read from address 5");
        pokeMem(7'd5, 32'h12345678);
        applyStimulus(8'h05, 1, 32'h12345678, 32'h0, 32'h0);
        checkFrame("rd1");

        $display("[TB] burst write with wrap from 126");
        applyStimulus(8'hFE, 3, 32'h11111111, 32'h22222222, 32'h33333333);
        checkFrame("burst");

        $display("[TB] abort after 20 data bits");
        expErr++;
        csLow();
        spiBits(32'h83, 8);
        spiBits(32'hABCDE, 20);
        csHigh();
        checkFrame("abort");
        applyStimulus(8'h83, 1, 32'hCAFEF00D, 32'h0, 32'h0);
        checkFrame("post_abort");

        $display("[TB] reset mid-frame after 12 bits");
        csLow();
        spiBits(32'h81, 8);
        spiBits(32'hB, 4);
        #50;
        iRST = 1'b1;
        #1;
        checkOutput("midrst_we", {31'h0, oMEM_WE}, 32'h0);
        checkOutput("midrst_addr", {25'h0, oMEM_ADDR}, 32'h0);
        checkOutput("midrst_wdata", oMEM_WDATA, 32'h0);
        checkOutput("midrst_miso", {31'h0, oSPI_MISO}, 32'h0);
        #100;
        iRST = 1'b0;
        #80;
        spiBits(32'h0ABCDEF, 28);
        csHigh();
        checkFrame("midrst_tail");
        applyStimulus(8'h81, 1, 32'h0BADCAFE, 32'h0, 32'h0);
        checkFrame("post_rst");

        $display("[TB] 4 MHz read burst from address 0");
        pokeMem(7'd0, 32'hA5A5A5A5);
        pokeMem(7'd1, 32'h5A5A5A5A);
        applyStimulus(8'h00, 2, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0);
        checkFrame("rd_burst");
        checkOutput("miso_stable", unstableCnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule
